// File: rtl/jump_enc_pkg.sv
// Shared definitions for the jump field encoder: opcodes, error codes,
// FSM state encoding and the captured request record.
package jump_enc_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_ALIGN  = 2'b01;
  localparam logic [1:0] ERR_REGION = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    HOLD  = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        link;
  } jump_req_t;

  // Top nibble of an address: the 256 MB region a J/JAL can reach.
  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[31:28];
  endfunction

endpackage

// File: rtl/jump_field_encoder_if.sv
// Request/result handshake bundle of the jump field encoder.
interface jump_field_encoder_if;

  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] target_i;
  logic        link_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [1:0]  err_o;
  logic [15:0] jump_cnt_o;

  // Encoder side.
  modport slave (
    input  valid_i, pc_i, target_i, link_i, ready_i,
    output ready_o, valid_o, instr_o, err_o, jump_cnt_o
  );

  // Requester / result consumer side.
  modport master (
    output valid_i, pc_i, target_i, link_i, ready_i,
    input  ready_o, valid_o, instr_o, err_o, jump_cnt_o
  );

endinterface

// File: rtl/jump_field_check.sv
// Purely combinational alignment/region check and J/JAL field packing.
module jump_field_check
  import jump_enc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic        link,
  output logic [31:0] instr,
  output logic [1:0]  err
);

  // Region is judged against the delay-slot address; wraps modulo 2^32.
  logic [31:0] pc_next;
  assign pc_next = pc + 32'd4;

  // Classify the request (misalignment wins) and pack the instruction word.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    err   = ERR_OK;
    instr = 32'h0000_0000;
    if (target[1:0] != 2'b00) begin
      err = ERR_ALIGN;
    end else if (region_of(target) != region_of(pc_next)) begin
      err = ERR_REGION;
    end
    if (err == ERR_OK) begin
      instr = {(link ? OP_JAL : OP_J), target[27:2]};
    end
  end

endmodule

// File: rtl/jump_field_encoder.sv
// Jump field encoder: captures a request, checks/encodes it for one cycle,
// then holds the result until the consumer takes it.
module jump_field_encoder
  import jump_enc_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  jump_field_encoder_if.slave  bus
);

  state_e      state_q, state_d;
  jump_req_t   req_q;
  logic [31:0] instr_q;
  logic [1:0]  err_q;
  logic [15:0] cnt_q;

  logic [31:0] chk_instr;
  logic [1:0]  chk_err;
  logic        accept;

  assign accept = bus.valid_i && (state_q == IDLE);

  jump_field_check u_check (
    .pc     (req_q.pc),
    .target (req_q.target),
    .link   (req_q.link),
    .instr  (chk_instr),
    .err    (chk_err)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> CHECK on accept, CHECK -> HOLD always, HOLD -> IDLE on consume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = CHECK;
      CHECK:                    state_d = HOLD;
      HOLD:    if (bus.ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       req_q <= '0;
    else if (accept) req_q <= '{pc: bus.pc_i, target: bus.target_i, link: bus.link_i};
  end

  // Register the check result in CHECK; it stays put through HOLD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= '0;
      err_q   <= ERR_OK;
    end else if (state_q == CHECK) begin
      instr_q <= chk_instr;
      err_q   <= chk_err;
    end
  end

  // Count successful encodings on CHECK -> HOLD; wraps naturally at 16 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    cnt_q <= '0;
    else if (state_q == CHECK && chk_err == ERR_OK) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = (state_q == HOLD);
  assign bus.instr_o    = instr_q;
  assign bus.err_o      = err_q;
  assign bus.jump_cnt_o = cnt_q;

endmodule

// File: tb/tb_jump_field_encoder.sv
// Self-checking bench for jump_field_encoder: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_jump_field_encoder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [15:0] cnt_model = 16'd0;

  always #5 clk_i = ~clk_i;

  jump_field_encoder_if bus ();

  jump_field_encoder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {err[1:0], instr[31:0]} from the encoding rules in plain arithmetic.
  function automatic logic [33:0] ref_encode(input logic [31:0] pc, input logic [31:0] tgt,
                                             input logic lnk);
    logic [31:0] nxt;
    logic [1:0]  e;
    logic [31:0] w;
    nxt = pc + 32'd4;
    if ((tgt % 4) != 0)               e = 2'd1;
    else if ((tgt >> 28) != (nxt >> 28)) e = 2'd2;
    else                              e = 2'd0;
    if (e == 2'd0) w = ((lnk ? 32'd3 : 32'd2) << 26) + ((tgt >> 2) & 32'h03FF_FFFF);
    else           w = 32'd0;
    return {e, w};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_instr"}, bus.instr_o, 32'd0);
    check({tag, "_err"},   32'(bus.err_o), 32'd0);
    check({tag, "_cnt"},   32'(bus.jump_cnt_o), 32'd0);
  endtask

  // One full transaction; result held for 'hold' cycles with ready_i=0.
  task automatic do_req(input logic [31:0] pc, input logic [31:0] tgt, input logic lnk,
                        input int hold);
    logic [33:0] exp;
    int t;
    t = 0;
    while (!bus.ready_o && t < 10) begin
      @(posedge clk_i); #1; t++;
    end
    check("ready_wait", 32'(bus.ready_o), 32'd1);
    bus.valid_i  = 1'b1;
    bus.pc_i     = pc;
    bus.target_i = tgt;
    bus.link_i   = lnk;
    @(posedge clk_i); #1;
    bus.valid_i  = 1'b0;
    bus.pc_i     = $urandom;
    bus.target_i = $urandom;
    bus.link_i   = 1'($urandom);
    check("chk_valid", 32'(bus.valid_o), 32'd0);
    check("chk_ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk_i); #1;
    exp = ref_encode(pc, tgt, lnk);
    if (exp[33:32] == 2'd0) cnt_model = cnt_model + 16'd1;
    check("res_valid", 32'(bus.valid_o), 32'd1);
    check("res_instr", bus.instr_o, exp[31:0]);
    check("res_err",   32'(bus.err_o), 32'(exp[33:32]));
    check("res_cnt",   32'(bus.jump_cnt_o), 32'(cnt_model));
    for (int i = 0; i < hold; i++) begin
      bus.valid_i  = 1'($urandom);
      bus.pc_i     = $urandom;
      bus.target_i = $urandom;
      @(posedge clk_i); #1;
      check("hold_valid", 32'(bus.valid_o), 32'd1);
      check("hold_ready", 32'(bus.ready_o), 32'd0);
      check("hold_instr", bus.instr_o, exp[31:0]);
      check("hold_err",   32'(bus.err_o), 32'(exp[33:32]));
      check("hold_cnt",   32'(bus.jump_cnt_o), 32'(cnt_model));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.ready_i = 1'b0;
    check("done_valid", 32'(bus.valid_o), 32'd0);
    check("done_ready", 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] pc, tgt, nxt;
    int acc, cpl;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.pc_i     = '0;
    bus.target_i = '0;
    bus.link_i   = 1'b0;

    // Reset state.
    #2;
    check_reset_values("rst");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Directed cases (first request right after reset release).
    do_req(32'h0040_0000, 32'h0040_0020, 1'b0, 0);
    check("dir1_cnt", 32'(bus.jump_cnt_o), 32'd1);
    do_req(32'h0040_0000, 32'h0040_0022, 1'b1, 1);
    check("dir2_cnt", 32'(bus.jump_cnt_o), 32'd1);
    do_req(32'h0FFF_FFFC, 32'h1000_0000, 1'b1, 0);
    do_req(32'hFFFF_FFFC, 32'hF000_0000, 1'b0, 0);
    do_req(32'hFFFF_FFFC, 32'hF000_0001, 1'b1, 0);
    do_req(32'h1234_5678, 32'h1ABC_DEF0, 1'b1, 5);

    // Peak throughput with valid_i and ready_i held high.
    acc = 0; cpl = 0;
    bus.pc_i = 32'h2000_0000; bus.target_i = 32'h2000_0100; bus.link_i = 1'b0;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.valid_i && bus.ready_o) acc++;
      if (bus.valid_o && bus.ready_i) cpl++;
      @(posedge clk_i); #1;
    end
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    cnt_model = cnt_model + 16'd10;
    check("tput_accepts", 32'(acc), 32'd10);
    check("tput_results", 32'(cpl), 32'd10);
    check("tput_cnt", 32'(bus.jump_cnt_o), 32'(cnt_model));

    // Randomized requests; bias toward aligned, in-region targets.
    for (int n = 0; n < 60; n++) begin
      pc  = $urandom;
      nxt = pc + 32'd4;
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[31:28] = nxt[31:28];
      if ($urandom_range(3) != 0) tgt[1:0]   = 2'b00;
      do_req(pc, tgt, 1'($urandom), int'($urandom_range(3)));
    end

    // Reset pulsed during CHECK drops the request.
    bus.valid_i = 1'b1;
    bus.pc_i = 32'h0040_0000; bus.target_i = 32'h0040_0040; bus.link_i = 1'b1;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    check("pre_rst_valid", 32'(bus.valid_o), 32'd0);
    check("pre_rst_ready", 32'(bus.ready_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check_reset_values("midrst");
    cnt_model = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("rst_hold_valid", 32'(bus.valid_o), 32'd0);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("post_rst_valid", 32'(bus.valid_o), 32'd0);
    end
    check_reset_values("postrst");
    do_req(32'h0040_0000, 32'h0040_0020, 1'b0, 0);
    check("post_rst_cnt", 32'(bus.jump_cnt_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/jump_field_encoder.md
JUMP_FIELD_ENCODER -- requirements
Module: jump_field_encoder

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  rising-edge clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i&&ready_o at clk_i edge.
- pc_i  in  32  byte address of the jump instruction.
- target_i  in  32  byte address of the jump destination.
- link_i  in  1  1=JAL, 0=J.
- valid_o  out  1  result valid.
- ready_i  in  1  result consumed when valid_o&&ready_i at clk_i edge.
- instr_o  out  32  encoded jump instruction.
- err_o  out  2  00 ok, 01 misaligned, 10 out of region.
- jump_cnt_o  out  16  count of successful encodings.

Function
REQ-003 The FSM SHALL have three states: IDLE, CHECK, HOLD.
REQ-004 ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in HOLD.
REQ-005 In IDLE, an accepted request SHALL capture pc_i, target_i and link_i into registers and move to CHECK; otherwise the FSM SHALL stay in IDLE.
REQ-006 CHECK SHALL last exactly one cycle, register instr_o/err_o, then go to HOLD; accept-to-valid_o latency is 2 cycles.
REQ-007 Misaligned: target[1:0]!=0 SHALL give err_o=01.
REQ-008 Out of region: target[31:28]!=(pc+32'd4)[31:28] SHALL give err_o=10, with pc+4 computed modulo 2^32.
REQ-009 When a request is both misaligned and out of region, misaligned SHALL take priority (err_o=01).
REQ-010 With err_o=00, instr_o SHALL be {opcode,target[27:2]}, opcode 6'b000010 (J) or 6'b000011 (JAL).
REQ-011 With err_o!=00, instr_o SHALL be 32'h0000_0000 (NOP).
REQ-012 In HOLD, instr_o and err_o SHALL remain stable until ready_i=1, then the FSM SHALL return to IDLE; ready_o rises the following cycle.
REQ-013 valid_i SHALL be ignored outside IDLE; input values SHALL be ignored after capture.
REQ-014 jump_cnt_o SHALL increment by 1 on the CHECK->HOLD transition when err_o=00, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-015 Peak throughput SHALL be one request per 3 cycles when ready_i is held at 1.

Reset
REQ-016 Asserting rst_i at any time SHALL asynchronously force state=IDLE, ready_o=1, valid_o=0, instr_o=0, err_o=00, jump_cnt_o=0, and all capture registers to 0.
REQ-017 An in-flight request SHALL be dropped by reset without producing valid_o.
REQ-018 After rst_i is deasserted, the first request SHALL be acceptable on the first clk_i edge.

Structure
REQ-019 A shared package jump_enc_pkg SHALL hold:
- opcode constants OP_J and OP_JAL;
- err_o code constants ERR_OK, ERR_ALIGN and ERR_REGION;
- the FSM state encoding.
REQ-020 The alignment/region check and field packing SHALL be one purely combinational sub-module, jump_field_check; the FSM, capture registers and counter SHALL be in jump_field_encoder.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- pc=0x0040_0000, target=0x0040_0020, link=0 -> after 2 cycles instr_o=0x0810_0008, err_o=00, jump_cnt_o=1.
- pc=0x0040_0000, target=0x0040_0022, link=1 -> instr_o=0, err_o=01, jump_cnt_o unchanged.
- pc=0x0FFF_FFFC, target=0x1000_0000, link=1 -> pc+4 lies in the same region, so instr_o=0x0C00_0000, err_o=00.
- pc=0xFFFF_FFFC, target=0xF000_0000 -> pc+4 wraps to region 0, so err_o=10; with target=0xF000_0001 the same case gives err_o=01 (priority).
- ready_i held 0 for 5 cycles in HOLD -> valid_o and instr_o stable, ready_o=0, and a new valid_i is ignored.
- rst_i pulsed during CHECK -> valid_o never asserts, and all outputs equal their reset values immediately.
